// File: rtl/cache_victim_ctrl_pkg.sv
// cache_victim_ctrl_pkg: shared cache geometry, controller state encoding and way helpers
package cache_victim_ctrl_pkg;

    localparam int WAYS = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        WB_WAIT   = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_WAIT = 3'd4,
        TOUCH     = 3'd5
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/cache_victim_ctrl_victim_sel.sv
// cache_victim_ctrl_victim_sel: picks the victim way and whether it needs a writeback
module cache_victim_ctrl_victim_sel
    import cache_victim_ctrl_pkg::*;
(
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] dirty,
    input  logic [WAYS-1:0] lru_way,
    output logic [WAYS-1:0] victim,
    output logic            need_wb
);

    localparam logic [WAYS-1:0] ONE = WAYS'(1);

    logic [WAYS-1:0] inv;
    logic [WAYS-1:0] first_inv;
    logic            lru_ok;

    assign inv       = ~valid;
    assign first_inv = inv & (~inv + ONE);
    assign lru_ok    = (lru_way != '0) && ((lru_way & (lru_way - ONE)) == '0);
    // an empty way always wins; a corrupt LRU hint falls back to way 0
    assign victim    = |inv ? first_inv : lru_ok ? lru_way : ONE;
    assign need_wb   = |(victim & valid & dirty);

endmodule

// File: rtl/cache_victim_ctrl.sv
// cache_victim_ctrl: miss-side victim selection, writeback/fill sequencing and LRU touch
module cache_victim_ctrl
    import cache_victim_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [WAYS-1:0]   way_valid,
    input  logic [WAYS-1:0]   way_dirty,
    input  logic [WAYS-1:0]   lru_way,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [WAYS-1:0]   wb_way,
    input  logic              wb_done,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [WAYS-1:0]   fill_way,
    input  logic              fill_done,
    output logic [WAYS-1:0]   lru_touch,
    output logic              lru_en,
    output logic              miss_done
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [WAYS-1:0]   victim_q;
    logic [WAYS-1:0]   victim_d;
    logic              need_wb_d;
    logic              accept;

    cache_victim_ctrl_victim_sel u_sel (
        .valid   (way_valid),
        .dirty   (way_dirty),
        .lru_way (lru_way),
        .victim  (victim_d),
        .need_wb (need_wb_d)
    );

    assign accept    = miss_valid && miss_ready;
    assign wb_way    = victim_q;
    assign fill_way  = victim_q;
    assign fill_addr = addr_q;

    // state register; the miss context is frozen at accept and held through TOUCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            victim_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q   <= miss_addr;
                victim_q <= victim_d;
            end
        end
    end

    // next state and handshake outputs, decoded from the current state only
    always_comb begin
        state_nx   = state;
        miss_ready = 1'b0;
        wb_valid   = 1'b0;
        fill_valid = 1'b0;
        lru_en     = 1'b0;
        miss_done  = 1'b0;
        lru_touch  = '0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_nx = need_wb_d ? WB_REQ : FILL_REQ;
            end
            WB_REQ: begin
                wb_valid = 1'b1;
                if (wb_ready) state_nx = WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_done) state_nx = FILL_REQ;
            end
            FILL_REQ: begin
                fill_valid = 1'b1;
                if (fill_ready) state_nx = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (fill_done) state_nx = TOUCH;
            end
            TOUCH: begin
                lru_en    = 1'b1;
                miss_done = 1'b1;
                lru_touch = victim_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
